prbs_pattern_gen: RTL
=====================

// Module: prbs_pattern_gen
// PURPOSE
//  Parametrised test-pattern source: loads a PAT_BYTES-byte user pattern, emits it n_repeats
//  times, then emits prbs_len beats of PRBS7/15/23/31 on a valid/ready stream. Next generation
//  of the Top_FPGA pattern path. Feeds the pattern detector and loopback checker.
//  Adds a selectable polynomial, downstream backpressure and a start/done handshake.
// PARAMETERS
//  DATA_W    8  beat width in bits (>=1, <=31)
//  PAT_BYTES 4  pattern length in beats (>=1)
//  CNT_W     8  width of n_repeats and prbs_len
// PORTS
//  clk           in   1          rising-edge clock
//  rst_n         in   1          asynchronous active-low reset
//  start         in   1          begin sequence; honoured only in IDLE
//  pattern_in    in   DATA_W     pattern beat, sampled in LOAD when pattern_valid=1
//  pattern_valid in   1          qualifies pattern_in
//  n_repeats     in   CNT_W      pattern repetitions, latched at start
//  prbs_sel      in   2          00 PRBS7, 01 PRBS15, 10 PRBS23, 11 PRBS31; latched at start
//  prbs_len      in   CNT_W      PRBS beats to emit, latched at start
//  out_data      out  DATA_W     stream data
//  out_valid     out  1          stream valid
//  out_ready     in   1          stream ready; beat transfers when out_valid&&out_ready
//  out_is_prbs   out  1          1 while the current beat is PRBS
//  busy          out  1          1 in any state except IDLE
//  done          out  1          single-cycle pulse at end of sequence
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, counters 0, pattern regs 0. LFSR reset to all ones.
//  States: IDLE -> LOAD -> REPEAT -> PRBS -> DONE -> IDLE. All transitions are registered.
//  IDLE: on start=1, latch n_repeats, prbs_sel, prbs_len. Load LFSR seed = all ones. Go to LOAD.
//  LOAD: each cycle with pattern_valid=1 stores pattern_in into slot k (k = 0..PAT_BYTES-1).
//   After slot PAT_BYTES-1 is stored: go to REPEAT if latched n_repeats!=0, else PRBS
//   if prbs_len!=0, else DONE. pattern_valid is ignored in all other states.
//  REPEAT: out_valid=1, out_data=slot[idx], out_is_prbs=0. On transfer: idx++ (wraps at
//   PAT_BYTES), rep++ at wrap. After the PAT_BYTES*n_repeats-th transfer: go to PRBS if
//   prbs_len!=0, else DONE. Beat counter width is CNT_W+clog2(PAT_BYTES); no overflow.
//  PRBS: out_valid=1, out_is_prbs=1. After prbs_len transfers, go to DONE.
//  LFSR: Fibonacci, N bits (7/15/23/31) with tap T (6/14/18/28).
//   Step: fb = s[N-1]^s[T-1]; s <= {s[N-2:0],fb}. Output bit = fb.
//   One beat = DATA_W steps combined in parallel. The first step's bit goes to out_data[DATA_W-1].
//   LFSR advances only on transfer. The next beat is precomputed so out_data is registered.
//  Backpressure: while out_valid&&!out_ready, out_data and out_is_prbs hold stable and
//   no counter or LFSR advances. out_valid never drops before its beat transfers.
//  REPEAT->PRBS is seamless: the first PRBS beat is valid in the cycle after the last pattern
//   transfer. No bubble is allowed under continuous out_ready=1.
//  DONE: out_valid=0, done=1 for exactly one cycle, then IDLE. busy=0 from IDLE entry.
//  start while busy: ignored. start in the DONE cycle: ignored.
//  start held high continuously restarts one cycle after each return to IDLE.
//  Reset mid-operation: immediate return to the reset values. No partial-sequence state survives.
//  Input changes after start do not affect the running sequence (latched values only).
// TESTING
//  1 Reset, start, load AB CD EF 58, n_repeats=3, prbs_len=0, out_ready=1 -> 12 beats
//    AB CD EF 58 x3, contiguous. done pulses once. busy returns to 0.
//  2 PRBS7, n_repeats=0, prbs_len=2, out_ready=1 -> beats 02 then 0C, out_is_prbs=1, done.
//  3 Case 1 with out_ready toggled pseudo-randomly -> identical beat sequence. out_data
//    stable whenever stalled. No beat lost or duplicated.
//  4 n_repeats=5, prbs_len=4 for each prbs_sel -> 20 pattern beats, then 4 PRBS beats
//    matching a reference LFSR model. No gap at the switch to PRBS.
//  5 Change n_repeats to 7 and pulse start mid-REPEAT -> both ignored. Sequence uses the
//    values latched at start.
//  6 Assert rst_n=0 mid-PRBS, then restart with pattern FA E1 89 EE -> outputs 0 during reset.
//    New run replays the new pattern. PRBS restarts from the all-ones seed.

Source files
------------

// File: rtl/prbs_pattern_gen_if.sv
// Stream and control bundle for prbs_pattern_gen: configuration/load inputs,
// valid/ready pattern stream and busy/done status.
interface prbs_pattern_gen_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [DATA_W-1:0] pattern_in;
    logic              pattern_valid;
    logic [CNT_W-1:0]  n_repeats;
    logic [1:0]        prbs_sel;
    logic [CNT_W-1:0]  prbs_len;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_is_prbs;
    logic              busy;
    logic              done;

    modport master (
        input  start, pattern_in, pattern_valid, n_repeats, prbs_sel, prbs_len, out_ready,
        output out_data, out_valid, out_is_prbs, busy, done
    );

    modport slave (
        output start, pattern_in, pattern_valid, n_repeats, prbs_sel, prbs_len, out_ready,
        input  out_data, out_valid, out_is_prbs, busy, done
    );
endinterface

// File: rtl/prbs_pattern_gen.sv
// Test-pattern source: loads a user pattern, replays it n_repeats times, then
// emits prbs_len beats of PRBS7/15/23/31 on a valid/ready stream.
module prbs_pattern_gen #(
    parameter int DATA_W    = 8,
    parameter int PAT_BYTES = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prbs_pattern_gen_if.master   bus
);

    localparam int IDX_W = (PAT_BYTES > 1) ? $clog2(PAT_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REPEAT,
        S_PRBS,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_rep_q, n_rep_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  rep_q, rep_d;
    logic [CNT_W-1:0]  prbs_cnt_q, prbs_cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] slot_q [PAT_BYTES];
    logic [DATA_W-1:0] slot_d [PAT_BYTES];
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [30:0]       lfsr_q, lfsr_d;
    logic [30:0]       lfsr_nxt;
    logic [DATA_W-1:0] prbs_beat;
    logic              xfer;

    // DATA_W serial Fibonacci steps unrolled; first generated bit lands in the MSB.
    function automatic logic [31+DATA_W-1:0] lfsr_beat(input logic [30:0] s_in,
                                                       input logic [1:0]  sel);
        logic [30:0]       s;
        logic [30:0]       mask;
        logic [4:0]        n_m1;
        logic [4:0]        t_m1;
        logic [DATA_W-1:0] d;
        logic              fb;
        s = s_in;
        d = '0;
        case (sel)
            2'b00:   begin n_m1 = 5'd6;  t_m1 = 5'd5;  mask = 31'h0000_007F; end
            2'b01:   begin n_m1 = 5'd14; t_m1 = 5'd13; mask = 31'h0000_7FFF; end
            2'b10:   begin n_m1 = 5'd22; t_m1 = 5'd17; mask = 31'h007F_FFFF; end
            default: begin n_m1 = 5'd30; t_m1 = 5'd27; mask = 31'h7FFF_FFFF; end
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            fb = s[n_m1] ^ s[t_m1];
            d[DATA_W-1-i] = fb;
            s = {s[29:0], fb} & mask;
        end
        return {s, d};
    endfunction

    assign {lfsr_nxt, prbs_beat} = lfsr_beat(lfsr_q, sel_q);
    assign xfer = ((state_q == S_REPEAT) || (state_q == S_PRBS)) && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        n_rep_d    = n_rep_q;
        len_d      = len_q;
        sel_d      = sel_q;
        rep_d      = rep_q;
        prbs_cnt_d = prbs_cnt_q;
        idx_d      = idx_q;
        slot_d     = slot_q;
        out_data_d = out_data_q;
        lfsr_d     = lfsr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_rep_d    = bus.n_repeats;
                    len_d      = bus.prbs_len;
                    sel_d      = bus.prbs_sel;
                    lfsr_d     = '1;
                    idx_d      = '0;
                    rep_d      = '0;
                    prbs_cnt_d = '0;
                    state_d    = S_LOAD;
                end
            end

            S_LOAD: begin
                if (bus.pattern_valid) begin
                    slot_d[idx_q] = bus.pattern_in;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        // slot_d[0] covers PAT_BYTES==1, where slot 0 is written this cycle.
                        if (n_rep_q != '0) begin
                            out_data_d = slot_d[0];
                            state_d    = S_REPEAT;
                        end else if (len_q != '0) begin
                            out_data_d = prbs_beat;
                            lfsr_d     = lfsr_nxt;
                            state_d    = S_PRBS;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_REPEAT: begin
                if (xfer) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        rep_d = rep_q + CNT_W'(1);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if ((idx_q == IDX_LAST) && (rep_q == n_rep_q - CNT_W'(1))) begin
                        // Preload the first PRBS beat so the switch has no bubble.
                        if (len_q != '0) begin
                            out_data_d = prbs_beat;
                            lfsr_d     = lfsr_nxt;
                            state_d    = S_PRBS;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        out_data_d = slot_q[idx_d];
                    end
                end
            end

            S_PRBS: begin
                if (xfer) begin
                    prbs_cnt_d = prbs_cnt_q + CNT_W'(1);
                    if (prbs_cnt_q == len_q - CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        out_data_d = prbs_beat;
                        lfsr_d     = lfsr_nxt;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_rep_q    <= '0;
            len_q      <= '0;
            sel_q      <= '0;
            rep_q      <= '0;
            prbs_cnt_q <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
            lfsr_q     <= '1;
            for (int i = 0; i < PAT_BYTES; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            n_rep_q    <= n_rep_d;
            len_q      <= len_d;
            sel_q      <= sel_d;
            rep_q      <= rep_d;
            prbs_cnt_q <= prbs_cnt_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            lfsr_q     <= lfsr_d;
            for (int i = 0; i < PAT_BYTES; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = (state_q == S_REPEAT) || (state_q == S_PRBS);
    assign bus.out_is_prbs = (state_q == S_PRBS);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);

endmodule
